// File: rtl/alu_arbiter_pkg.sv
// Shared constants for the ALU arbiter: data width, ALU opcodes,
// FSM state encoding and a small grant helper.
package alu_arbiter_pkg;

    localparam int DATA_WIDTH = 32;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } arb_state_e;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between two requesters and the ALU arbiter.
// master = requester side, slave = arbiter side.
interface alu_arbiter_if #(
    parameter int DATA_WIDTH = alu_arbiter_pkg::DATA_WIDTH
);

    logic [1:0]            req_valid;
    logic [1:0]            req_ready;
    logic [DATA_WIDTH-1:0] req0_A;
    logic [DATA_WIDTH-1:0] req0_B;
    logic [2:0]            req0_ALUop;
    logic [DATA_WIDTH-1:0] req1_A;
    logic [DATA_WIDTH-1:0] req1_B;
    logic [2:0]            req1_ALUop;

    logic [1:0]            resp_valid;
    logic [1:0]            resp_ready;
    logic [DATA_WIDTH-1:0] resp_Result;
    logic                  resp_Overflow;
    logic                  resp_CarryOut;
    logic                  resp_Zero;

    modport master (
        output req_valid,
        output req0_A,
        output req0_B,
        output req0_ALUop,
        output req1_A,
        output req1_B,
        output req1_ALUop,
        output resp_ready,
        input  req_ready,
        input  resp_valid,
        input  resp_Result,
        input  resp_Overflow,
        input  resp_CarryOut,
        input  resp_Zero
    );

    modport slave (
        input  req_valid,
        input  req0_A,
        input  req0_B,
        input  req0_ALUop,
        input  req1_A,
        input  req1_B,
        input  req1_ALUop,
        input  resp_ready,
        output req_ready,
        output resp_valid,
        output resp_Result,
        output resp_Overflow,
        output resp_CarryOut,
        output resp_Zero
    );

endinterface

// File: rtl/alu_arbiter_alu.sv
// 32-bit combinational ALU: AND, OR, ADD, SUB, SLT.
// Overflow/CarryOut come from the adder and are reported for ADD/SUB only.
module alu
    import alu_arbiter_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    input  logic [2:0]            ALUop,
    output logic                  Overflow,
    output logic                  CarryOut,
    output logic                  Zero,
    output logic [DATA_WIDTH-1:0] Result
);

    localparam int MSB = DATA_WIDTH - 1;

    logic                  sub;
    logic [DATA_WIDTH-1:0] b_eff;
    logic [DATA_WIDTH:0]   sum;
    logic                  add_ovf;

    // SUB and SLT share the adder as A + ~B + 1
    always_comb begin
        sub     = ALUop[2];
        b_eff   = sub ? ~B : B;
        sum     = {1'b0, A} + {1'b0, b_eff}
                + {{DATA_WIDTH{1'b0}}, sub};
        add_ovf = (A[MSB] == b_eff[MSB]) && (sum[MSB] != A[MSB]);
    end

    always_comb begin
        Result   = '0;
        Overflow = 1'b0;
        CarryOut = 1'b0;
        case (ALUop)
            ALU_AND: Result = A & B;
            ALU_OR:  Result = A | B;
            ALU_ADD,
            ALU_SUB: begin
                Result   = sum[MSB:0];
                Overflow = add_ovf;
                CarryOut = sum[DATA_WIDTH];
            end
            ALU_SLT: Result = {{MSB{1'b0}}, sum[MSB] ^ add_ovf};
            default: Result = '0;
        endcase
        Zero = (Result == '0);
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between two valid/ready requesters.
// IDLE accepts, EXEC evaluates registered operands, RESP holds the result.
module alu_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_arbiter_if.slave         bus,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] op_count
);

    import alu_arbiter_pkg::*;

    arb_state_e            state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  last_grant_q, last_grant_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [2:0]            op_q, op_d;
    logic [DATA_WIDTH-1:0] res_q, res_d;
    logic                  ovf_q, ovf_d;
    logic                  cout_q, cout_d;
    logic                  zero_q, zero_d;
    logic [1:0]            rvld_q, rvld_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    logic                  winner;
    logic [1:0]            req_ready;
    logic                  hs;

    logic [DATA_WIDTH-1:0] alu_res;
    logic                  alu_ovf;
    logic                  alu_cout;
    logic                  alu_zero;

    alu u_alu (
        .A        (a_q),
        .B        (b_q),
        .ALUop    (op_q),
        .Overflow (alu_ovf),
        .CarryOut (alu_cout),
        .Zero     (alu_zero),
        .Result   (alu_res)
    );

    // On a tie the requester not granted last time wins
    always_comb begin
        winner    = (&bus.req_valid) ? ~last_grant_q
                                     : bus.req_valid[1];
        req_ready = 2'b00;
        if (state_q == ST_IDLE && rst_n && |bus.req_valid)
            req_ready = onehot2(winner);
        hs        = |(bus.req_valid & req_ready);
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        res_d        = res_q;
        ovf_d        = ovf_q;
        cout_d       = cout_q;
        zero_d       = zero_q;
        rvld_d       = rvld_q;
        cnt_d        = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (hs) begin
                    a_d     = winner ? bus.req1_A : bus.req0_A;
                    b_d     = winner ? bus.req1_B : bus.req0_B;
                    op_d    = winner ? bus.req1_ALUop
                                     : bus.req0_ALUop;
                    owner_d = winner;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                res_d   = alu_res;
                ovf_d   = alu_ovf;
                cout_d  = alu_cout;
                zero_d  = alu_zero;
                rvld_d  = onehot2(owner_q);
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (bus.resp_ready[owner_q]) begin
                    rvld_d       = 2'b00;
                    cnt_d        = cnt_q + 1'b1;
                    last_grant_d = owner_q;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                rvld_d  = 2'b00;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            res_q        <= '0;
            ovf_q        <= 1'b0;
            cout_q       <= 1'b0;
            zero_q       <= 1'b0;
            rvld_q       <= 2'b00;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            res_q        <= res_d;
            ovf_q        <= ovf_d;
            cout_q       <= cout_d;
            zero_q       <= zero_d;
            rvld_q       <= rvld_d;
            cnt_q        <= cnt_d;
        end
    end

    assign bus.req_ready     = req_ready;
    assign bus.resp_valid    = rvld_q;
    assign bus.resp_Result   = res_q;
    assign bus.resp_Overflow = ovf_q;
    assign bus.resp_CarryOut = cout_q;
    assign bus.resp_Zero     = zero_q;
    assign busy              = (state_q != ST_IDLE);
    assign op_count          = cnt_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: reset, round-robin, flags,
// backpressure and reset during an operation.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        busy;
    logic [31:0] op_count;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_cnt = 0;

    alu_arbiter_if #(.DATA_WIDTH(32)) bus ();

    alu_arbiter #(
        .DATA_WIDTH (32),
        .CNT_WIDTH  (32)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .busy     (busy),
        .op_count (op_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int p, input logic [2:0] op,
                           input logic [31:0] a,
                           input logic [31:0] b);
        if (p == 0) begin
            bus.req0_ALUop = op;
            bus.req0_A     = a;
            bus.req0_B     = b;
        end else begin
            bus.req1_ALUop = op;
            bus.req1_A     = a;
            bus.req1_B     = b;
        end
        bus.req_valid[p] = 1'b1;
    endtask

    // Called at a negedge in IDLE with the request already presented.
    task automatic do_op(input string tag, input int p,
                         input logic [31:0] r, input logic v,
                         input logic c, input logic z,
                         input logic keep);
        logic [1:0] oh;
        oh = (p == 1) ? 2'b10 : 2'b01;
        #1;
        chk({tag, ".rdy"}, 64'(bus.req_ready), 64'(oh));
        @(posedge clk);
        @(negedge clk);
        if (!keep) bus.req_valid[p] = 1'b0;
        #1;
        chk({tag, ".exec_busy"}, 64'(busy), 64'd1);
        chk({tag, ".exec_vld"}, 64'(bus.resp_valid), 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk({tag, ".vld"}, 64'(bus.resp_valid), 64'(oh));
        chk({tag, ".res"}, 64'(bus.resp_Result), 64'(r));
        chk({tag, ".ovf"}, 64'(bus.resp_Overflow), 64'(v));
        chk({tag, ".cout"}, 64'(bus.resp_CarryOut), 64'(c));
        chk({tag, ".zero"}, 64'(bus.resp_Zero), 64'(z));
        bus.resp_ready = oh;
        @(posedge clk);
        exp_cnt++;
        @(negedge clk);
        bus.resp_ready = 2'b00;
        #1;
        chk({tag, ".done_vld"}, 64'(bus.resp_valid), 64'd0);
        chk({tag, ".done_busy"}, 64'(busy), 64'd0);
        chk({tag, ".cnt"}, 64'(op_count), 64'(exp_cnt));
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, ".rdy"}, 64'(bus.req_ready), 64'd0);
        chk({tag, ".vld"}, 64'(bus.resp_valid), 64'd0);
        chk({tag, ".res"}, 64'(bus.resp_Result), 64'd0);
        chk({tag, ".flags"},
            64'({bus.resp_Overflow, bus.resp_CarryOut,
                 bus.resp_Zero}), 64'd0);
        chk({tag, ".busy"}, 64'(busy), 64'd0);
        chk({tag, ".cnt"}, 64'(op_count), 64'd0);
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.req_valid  = 2'b00;
        bus.resp_ready = 2'b00;
        set_req(0, 3'b010, 32'd5, 32'd3);
        bus.req_valid  = 2'b01;
        set_req(1, 3'b000, 32'd0, 32'd0);
        bus.req_valid[1] = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_reset_state("rst");

        // basic add, accepted right after reset release
        rst_n = 1'b1;
        do_op("add", 0, 32'd8, 1'b0, 1'b0, 1'b0, 1'b0);

        // reset pulse, then a tie from reset: port 0 wins first
        @(negedge clk);
        rst_n   = 1'b0;
        exp_cnt = 0;
        set_req(0, 3'b010, 32'd1, 32'd1);
        set_req(1, 3'b110, 32'd9, 32'd4);
        #1;
        check_reset_state("rst2");
        @(negedge clk);
        rst_n = 1'b1;
        do_op("tie0", 0, 32'd2, 1'b0, 1'b0, 1'b0, 1'b1);
        do_op("rr1", 1, 32'd5, 1'b0, 1'b1, 1'b0, 1'b1);
        do_op("rr0", 0, 32'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        do_op("rr1b", 1, 32'd5, 1'b0, 1'b1, 1'b0, 1'b0);

        set_req(1, 3'b010, 32'h7FFF_FFFF, 32'h0000_0001);
        do_op("ovf", 1, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 1'b0);

        set_req(0, 3'b110, 32'h1234, 32'h1234);
        do_op("zero", 0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0);

        // backpressure on port 0 while port 1 waits
        set_req(0, 3'b000, 32'h0000_F0F0, 32'h0000_FF00);
        #1;
        chk("bp.rdy0", 64'(bus.req_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid[0] = 1'b0;
        set_req(1, 3'b001, 32'h0F, 32'hF0);
        #1;
        chk("bp.exec_rdy", 64'(bus.req_ready), 64'd0);
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.resp_ready = 2'b10;
            #1;
            chk("bp.vld", 64'(bus.resp_valid), 64'd1);
            chk("bp.res", 64'(bus.resp_Result), 64'h0000_F000);
            chk("bp.rdy", 64'(bus.req_ready), 64'd0);
            @(posedge clk);
        end
        @(negedge clk);
        bus.resp_ready = 2'b01;
        #1;
        chk("bp.cons_rdy", 64'(bus.req_ready), 64'd0);
        chk("bp.cons_cnt", 64'(op_count), 64'(exp_cnt));
        @(posedge clk);
        exp_cnt++;
        @(negedge clk);
        bus.resp_ready = 2'b00;
        #1;
        chk("bp.cnt", 64'(op_count), 64'(exp_cnt));
        do_op("bp1", 1, 32'hFF, 1'b0, 1'b0, 1'b0, 1'b0);

        // reset while in EXEC discards the operation
        set_req(0, 3'b010, 32'd2, 32'd2);
        #1;
        chk("mid.rdy", 64'(bus.req_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("mid.busy", 64'(busy), 64'd1);
        rst_n   = 1'b0;
        exp_cnt = 0;
        #1;
        check_reset_state("mid");
        @(posedge clk);
        @(negedge clk);
        chk("mid.vld2", 64'(bus.resp_valid), 64'd0);
        rst_n = 1'b1;
        do_op("post", 0, 32'd4, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
